// File: rtl/security_alert_ctrl.sv
// Multi-zone security alert controller: arming, zone masking, timed escalation,
// acknowledge and post-ack cooldown driving app/email/SMS notification requests.
module security_alert_ctrl #(
  parameter int NUM_ZONES       = 4,
  parameter int ESCALATE_CYCLES = 32,
  parameter int HOLD_CYCLES     = 16,
  parameter int CNT_W           = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 arm,
  input  logic                 ack,
  input  logic [NUM_ZONES-1:0] zone_mask,
  input  logic [NUM_ZONES-1:0] intruder_detected,
  input  logic [NUM_ZONES-1:0] system_compromised,
  output logic                 app_alert,
  output logic                 email_alert,
  output logic                 sms_alert,
  output logic [NUM_ZONES-1:0] alert_zone,
  output logic [2:0]           alert_state,
  output logic [CNT_W-1:0]     event_count
);

  localparam int MAX_CYC = (ESCALATE_CYCLES > HOLD_CYCLES) ? ESCALATE_CYCLES : HOLD_CYCLES;
  localparam int TMR_W   = $clog2(MAX_CYC);

  localparam logic [2:0] S_DISARMED  = 3'd0;
  localparam logic [2:0] S_ARMED     = 3'd1;
  localparam logic [2:0] S_ALERT     = 3'd2;
  localparam logic [2:0] S_ESCALATED = 3'd3;
  localparam logic [2:0] S_COOLDOWN  = 3'd4;

  localparam logic [TMR_W-1:0] ESC_LAST  = TMR_W'(ESCALATE_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  logic [2:0]           state;
  logic [2:0]           next_state;
  logic [TMR_W-1:0]     timer;
  logic [NUM_ZONES-1:0] prev_comp;
  logic [NUM_ZONES-1:0] intr_vec;
  logic [NUM_ZONES-1:0] rise_vec;
  logic [NUM_ZONES-1:0] zone_hits;
  logic [NUM_ZONES-1:0] zone_next;
  logic                 intr;
  logic                 comp_rise;
  logic                 count_inc;

  assign intr_vec  = intruder_detected & ~zone_mask;
  assign rise_vec  = system_compromised & ~prev_comp & ~zone_mask;
  assign zone_hits = intr_vec | rise_vec;
  assign intr      = |intr_vec;
  assign comp_rise = |rise_vec;

  always_comb begin
    next_state = S_DISARMED;
    case (state)
      S_DISARMED:  next_state = arm ? S_ARMED : S_DISARMED;
      S_ARMED: begin
        if (!arm)           next_state = S_DISARMED;
        else if (comp_rise) next_state = S_ESCALATED;
        else if (intr)      next_state = S_ALERT;
        else                next_state = S_ARMED;
      end
      S_ALERT: begin
        if (comp_rise)              next_state = S_ESCALATED;
        else if (ack)               next_state = S_COOLDOWN;
        else if (!arm)              next_state = S_DISARMED;
        else if (timer == ESC_LAST) next_state = S_ESCALATED;
        else                        next_state = S_ALERT;
      end
      // Once escalated only an acknowledge can silence the alarm; disarming is ignored.
      S_ESCALATED: next_state = ack ? S_COOLDOWN : S_ESCALATED;
      S_COOLDOWN: begin
        if (comp_rise)               next_state = S_ESCALATED;
        else if (!arm)               next_state = S_DISARMED;
        else if (timer == HOLD_LAST) next_state = S_ARMED;
        else                         next_state = S_COOLDOWN;
      end
      default:     next_state = S_DISARMED;
    endcase
  end

  always_comb begin
    zone_next = '0;
    case (state)
      S_ARMED, S_COOLDOWN:    zone_next = alert_zone | zone_hits;
      S_ALERT, S_ESCALATED:   zone_next = (ack ? '0 : alert_zone) | zone_hits;
      default:                zone_next = '0;
    endcase
  end

  assign count_inc = (state == S_ARMED) &&
                     ((next_state == S_ALERT) || (next_state == S_ESCALATED));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_DISARMED;
      timer       <= '0;
      prev_comp   <= '0;
      alert_zone  <= '0;
      event_count <= '0;
    end else begin
      state      <= next_state;
      prev_comp  <= system_compromised;
      alert_zone <= zone_next;
      if (next_state != state)
        timer <= '0;
      else if ((state == S_ALERT) || (state == S_COOLDOWN))
        timer <= timer + 1'b1;
      else
        timer <= '0;
      if (count_inc && (event_count != CNT_MAX))
        event_count <= event_count + 1'b1;
    end
  end

  always_comb begin
    app_alert   = 1'b0;
    email_alert = 1'b0;
    sms_alert   = 1'b0;
    case (state)
      S_ALERT:     app_alert = 1'b1;
      S_ESCALATED: begin
        app_alert   = 1'b1;
        email_alert = 1'b1;
        sms_alert   = 1'b1;
      end
      default: ;
    endcase
  end

  assign alert_state = state;

endmodule
